onehot_rr_arbiter: RTL and testbench

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

---
 rtl/onehot_rr_arbiter.sv | 89 ++++++++
 tb/tb_onehot_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: 8-way round-robin arbiter with a registered one-hot grant.
// Define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles and flag it on o_timeout_pulse.
module onehot_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_done,
    output logic [7:0] o_grant,
    output logic [2:0] o_grant_bin,
    output logic       o_grant_valid,
    output logic       o_timeout_pulse
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] w_win;
    logic       w_found;
    logic       w_timeout;
    logic       w_release;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("onehot_rr_arbiter: HOLD_MAX must be within 2..255");
    end

    // First set request at or above r_ptr, wrapping 7 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 0; k < 8; k++) begin
            if (!w_found && i_req[r_ptr + 3'(k)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 3'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;
    assign w_timeout = (r_hold_cnt == 8'(HOLD_MAX - 1)) && !i_done && i_req[o_grant_bin];
`else
    assign w_timeout       = 1'b0;
    assign o_timeout_pulse = 1'b0;
`endif

    assign w_release = i_done || !i_req[o_grant_bin] || w_timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= 3'd0;
            o_grant         <= 8'h00;
            o_grant_bin     <= 3'd0;
            o_grant_valid   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            o_timeout_pulse <= 1'b0;
            r_hold_cnt      <= 8'd0;
`endif
        end else if (r_state == S_IDLE) begin
`ifdef ARB_TIMEOUT_EN
            o_timeout_pulse <= 1'b0;
            r_hold_cnt      <= 8'd0;
`endif
            if (w_found) begin
                r_state       <= S_GRANT;
                o_grant       <= 8'd1 << w_win;
                o_grant_bin   <= w_win;
                o_grant_valid <= 1'b1;
            end else begin
                o_grant       <= 8'h00;
                o_grant_valid <= 1'b0;
            end
        end else if (w_release) begin
            r_state         <= S_IDLE;
            r_ptr           <= o_grant_bin + 3'd1;
            o_grant         <= 8'h00;
            o_grant_valid   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            o_timeout_pulse <= w_timeout;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt      <= r_hold_cnt + 8'd1;
`endif
        end
    end
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: directed vectors for onehot_rr_arbiter; follows ARB_TIMEOUT_EN when defined.
module tb_onehot_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_bin;
    logic       grant_valid;
    logic       timeout_pulse;
    int         n_checks = 0;
    int         n_errors = 0;

    onehot_rr_arbiter #(.HOLD_MAX(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_done         (done),
        .o_grant        (grant),
        .o_grant_bin    (grant_bin),
        .o_grant_valid  (grant_valid),
        .o_timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", 8'(grant_valid), 8'd0);
        chk("rst_bin", 8'(grant_bin), 8'd0);
        chk("rst_tp", 8'(timeout_pulse), 8'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_grant", grant, 8'h00);
            chk("idle_valid", 8'(grant_valid), 8'd0);
        end
        req = 8'b0010_0100;
        tick();
        chk("first_grant", grant, 8'h04);
        chk("first_bin", 8'(grant_bin), 8'd2);
        chk("first_valid", 8'(grant_valid), 8'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_gap", grant, 8'h00);
        chk("done_gap_valid", 8'(grant_valid), 8'd0);
        chk("gap_bin_hold", 8'(grant_bin), 8'd2);
        tick();
        chk("second_grant", grant, 8'h20);
        chk("second_bin", 8'(grant_bin), 8'd5);
        req = 8'h00;
        tick();
        chk("drop_release", grant, 8'h00);
        tick();
        reset_pulse();
        req  = 8'hFF;
        done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rr_grant", grant, 8'd1 << (i % 8));
            chk("rr_bin", 8'(grant_bin), 8'(i % 8));
            tick();
            chk("rr_gap", grant, 8'h00);
            chk("rr_gap_valid", 8'(grant_valid), 8'd0);
        end
        req  = 8'h00;
        done = 1'b0;
        tick();
        req = 8'b0100_1000;
        tick();
        chk("own3_grant", grant, 8'h08);
        tick();
        chk("own3_hold", grant, 8'h08);
        req = 8'b0100_0000;
        tick();
        chk("own3_drop", grant, 8'h00);
        tick();
        chk("own6_grant", grant, 8'h40);
        chk("own6_bin", 8'(grant_bin), 8'd6);
        req = 8'h00;
        tick();
        done = 1'b1;
        tick();
        chk("done_in_idle", grant, 8'h00);
        done = 1'b0;
        req  = 8'h02;
        tick();
        chk("hold_grant", grant, 8'h02);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold", grant, 8'h02);
            chk("to_hold_tp", 8'(timeout_pulse), 8'd0);
        end
        tick();
        chk("to_release", grant, 8'h00);
        chk("to_pulse", 8'(timeout_pulse), 8'd1);
        tick();
        chk("to_regrant", grant, 8'h02);
        chk("to_pulse_end", 8'(timeout_pulse), 8'd0);
        for (int i = 0; i < 3; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("to_done_release", grant, 8'h00);
        chk("to_done_no_pulse", 8'(timeout_pulse), 8'd0);
`else
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("no_to_hold", grant, 8'h02);
            chk("no_to_tp", 8'(timeout_pulse), 8'd0);
        end
`endif
        req = 8'h00;
        tick();
        tick();
        req = 8'h10;
        tick();
        chk("mid_grant", grant, 8'h10);
        chk("mid_bin", 8'(grant_bin), 8'd4);
        req = 8'hFF;
        reset_pulse();
        tick();
        chk("post_rst_grant", grant, 8'h01);
        chk("post_rst_bin", 8'(grant_bin), 8'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
